// File: rtl/stream_rr_sched_if.sv
// Scheduler channel bundle: producer-side req/ack/data plus the single
// downstream req/ack channel and status outputs.
interface stream_rr_sched_if #(
  parameter int DWIDTH     = 16,
  parameter int NR_STREAMS = 16,
  parameter int IWIDTH     = 4
);
  logic [NR_STREAMS-1:0]        stream_en;
  logic [NR_STREAMS-1:0]        req_in;
  logic [NR_STREAMS-1:0]        ack_in;
  logic [NR_STREAMS*DWIDTH-1:0] data_in;
  logic                         req_out;
  logic                         ack_out;
  logic [DWIDTH-1:0]            data_out;
  logic [IWIDTH-1:0]            idx_out;
  logic                         frame_end;
  logic [15:0]                  skip_cnt;

  // scheduler side
  modport master (
    input  stream_en, ack_in, data_in, ack_out,
    output req_in, req_out, data_out, idx_out, frame_end, skip_cnt
  );

  // producers/consumer side
  modport slave (
    output stream_en, ack_in, data_in, ack_out,
    input  req_in, req_out, data_out, idx_out, frame_end, skip_cnt
  );
endinterface

// File: rtl/stream_rr_sched.sv
// Round-robin scheduler: fetches one word per enabled stream in index order
// and forwards it with its stream index on a single req/ack channel. Streams
// that do not answer within TIMEOUT cycles are skipped and counted.
module stream_rr_sched #(
  parameter int DWIDTH     = 16,
  parameter int NR_STREAMS = 16,
  parameter int IWIDTH     = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              rst,
  stream_rr_sched_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

  localparam logic [IWIDTH-1:0] LAST_PTR = IWIDTH'(NR_STREAMS - 1);
  localparam logic [31:0]       WAIT_END = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

  state_t                          state_q, state_d;
  logic [IWIDTH-1:0]               ptr_q, ptr_d;
  logic [31:0]                     wait_cnt_q, wait_cnt_d;
  logic [NR_STREAMS-1:0]           req_in_q, req_in_d;
  logic                            req_out_q, req_out_d;
  logic [DWIDTH-1:0]               data_out_q, data_out_d;
  logic [IWIDTH-1:0]               idx_out_q, idx_out_d;
  logic                            frame_end_q, frame_end_d;
  logic [15:0]                     skip_cnt_q, skip_cnt_d;

  logic [NR_STREAMS-1:0][DWIDTH-1:0] data_arr;
  logic [IWIDTH-1:0]                 ptr_nxt;
  logic                              ptr_wrap;

  assign data_arr = bus.data_in;
  assign ptr_wrap = (ptr_q == LAST_PTR);
  assign ptr_nxt  = ptr_wrap ? '0 : ptr_q + 1'b1;

  // Next-state and next-output logic for the IDLE/FETCH/SEND walk.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    wait_cnt_d  = wait_cnt_q;
    req_in_d    = req_in_q;
    req_out_d   = req_out_q;
    data_out_d  = data_out_q;
    idx_out_d   = idx_out_q;
    frame_end_d = 1'b0;
    skip_cnt_d  = skip_cnt_q;
    case (state_q)
      IDLE: begin
        // mask is only looked at here; disabled streams cost one cycle each
        if (bus.stream_en[ptr_q]) begin
          req_in_d        = '0;
          req_in_d[ptr_q] = 1'b1;
          wait_cnt_d      = '0;
          state_d         = FETCH;
        end else begin
          ptr_d       = ptr_nxt;
          frame_end_d = ptr_wrap;
        end
      end
      FETCH: begin
        // only the addressed stream's ack counts
        if (bus.ack_in[ptr_q]) begin
          data_out_d = data_arr[ptr_q];
          idx_out_d  = ptr_q;
          req_in_d   = '0;
          req_out_d  = 1'b1;
          state_d    = SEND;
        end else if (TIMEOUT != 0 && wait_cnt_q == WAIT_END) begin
          req_in_d    = '0;
          skip_cnt_d  = (skip_cnt_q == 16'hFFFF) ? skip_cnt_q : skip_cnt_q + 16'd1;
          ptr_d       = ptr_nxt;
          frame_end_d = ptr_wrap;
          state_d     = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 32'd1;
        end
      end
      SEND: begin
        // word held stable until the consumer takes it
        if (bus.ack_out) begin
          req_out_d   = 1'b0;
          data_out_d  = '0;
          ptr_d       = ptr_nxt;
          frame_end_d = ptr_wrap;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      wait_cnt_q  <= '0;
      req_in_q    <= '0;
      req_out_q   <= 1'b0;
      data_out_q  <= '0;
      idx_out_q   <= '0;
      frame_end_q <= 1'b0;
      skip_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      wait_cnt_q  <= wait_cnt_d;
      req_in_q    <= req_in_d;
      req_out_q   <= req_out_d;
      data_out_q  <= data_out_d;
      idx_out_q   <= idx_out_d;
      frame_end_q <= frame_end_d;
      skip_cnt_q  <= skip_cnt_d;
    end
  end

  assign bus.req_in    = req_in_q;
  assign bus.req_out   = req_out_q;
  assign bus.data_out  = data_out_q;
  assign bus.idx_out   = idx_out_q;
  assign bus.frame_end = frame_end_q;
  assign bus.skip_cnt  = skip_cnt_q;

endmodule

// File: tb/tb_stream_rr_sched.sv
// Directed bench for stream_rr_sched with 4 streams and an 8-cycle timeout.
module tb_stream_rr_sched;
  localparam int DW = 16;
  localparam int NS = 4;
  localparam int IW = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   got_idx[$];
  int   got_data[$];
  int   got_cyc[$];
  int   fe_cyc[$];
  int   reqhi[NS];
  int   viol;

  stream_rr_sched_if #(.DWIDTH(DW), .NR_STREAMS(NS), .IWIDTH(IW)) bus ();

  stream_rr_sched #(.DWIDTH(DW), .NR_STREAMS(NS), .IWIDTH(IW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  // Runs up to maxc cycles, logging transfers, frame_end pulses, per-stream
  // request cycles and protocol violations; stops after n transfers.
  task automatic collect(input int n, input int maxc);
    got_idx.delete(); got_data.delete(); got_cyc.delete(); fe_cyc.delete();
    for (int i = 0; i < NS; i++) reqhi[i] = 0;
    viol = 0;
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk);
      cyc++;
      if (bus.frame_end) fe_cyc.push_back(cyc);
      for (int i = 0; i < NS; i++) if (bus.req_in[i]) reqhi[i]++;
      if ($countones(bus.req_in) > 1 || (bus.req_in != 0 && bus.req_out) ||
          (!bus.req_out && bus.data_out != 0)) viol++;
      if (bus.req_out && bus.ack_out) begin
        got_idx.push_back(int'(bus.idx_out));
        got_data.push_back(int'(bus.data_out));
        got_cyc.push_back(cyc);
        if (got_idx.size() == n) break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (bus.req_in !== 4'h0) begin failures++; $display("FAIL reset_req_in got=%h exp=0", bus.req_in); end
    checks++; if (bus.req_out !== 1'b0) begin failures++; $display("FAIL reset_req_out got=%b exp=0", bus.req_out); end
    checks++; if (bus.data_out !== 16'h0) begin failures++; $display("FAIL reset_data_out got=%h exp=0", bus.data_out); end
    checks++; if (bus.idx_out !== 4'h0) begin failures++; $display("FAIL reset_idx_out got=%h exp=0", bus.idx_out); end
    checks++; if (bus.frame_end !== 1'b0) begin failures++; $display("FAIL reset_frame_end got=%b exp=0", bus.frame_end); end
    checks++; if (bus.skip_cnt !== 16'h0) begin failures++; $display("FAIL reset_skip_cnt got=%h exp=0", bus.skip_cnt); end
  endtask

  task automatic test_rotation();
    int exp_idx[5] = '{0, 1, 2, 3, 0};
    bus.stream_en = 4'hF; bus.ack_in = 4'hF; bus.ack_out = 1'b1;
    apply_reset();
    collect(5, 40);
    checks++; if (got_idx.size() != 5) begin failures++; $display("FAIL rot_count got=%0d exp=5", got_idx.size()); end
    for (int k = 0; k < got_idx.size() && k < 5; k++) begin
      checks++; if (got_idx[k] != exp_idx[k]) begin failures++; $display("FAIL rot_idx%0d got=%0d exp=%0d", k, got_idx[k], exp_idx[k]); end
      checks++; if (got_data[k] != 16'h10 + exp_idx[k]) begin failures++; $display("FAIL rot_data%0d got=%h exp=%h", k, got_data[k], 16'h10 + exp_idx[k]); end
    end
    if (got_cyc.size() == 5) begin
      checks++; if (got_cyc[0] != 2) begin failures++; $display("FAIL rot_first_lat got=%0d exp=2", got_cyc[0]); end
      for (int k = 1; k < 5; k++) begin
        checks++; if (got_cyc[k] - got_cyc[k-1] != 3) begin failures++; $display("FAIL rot_gap%0d got=%0d exp=3", k, got_cyc[k] - got_cyc[k-1]); end
      end
      checks++; if (fe_cyc.size() != 1) begin failures++; $display("FAIL rot_fe_count got=%0d exp=1", fe_cyc.size()); end
      else begin
        checks++; if (fe_cyc[0] != got_cyc[3] + 1) begin failures++; $display("FAIL rot_fe_cycle got=%0d exp=%0d", fe_cyc[0], got_cyc[3] + 1); end
      end
    end
    checks++; if (viol != 0) begin failures++; $display("FAIL rot_protocol got=%0d exp=0", viol); end
  endtask

  task automatic test_mask();
    int exp_idx[4] = '{1, 3, 1, 3};
    bus.stream_en = 4'b1010; bus.ack_in = 4'hF; bus.ack_out = 1'b1;
    apply_reset();
    collect(4, 40);
    checks++; if (got_idx.size() != 4) begin failures++; $display("FAIL mask_count got=%0d exp=4", got_idx.size()); end
    for (int k = 0; k < got_idx.size() && k < 4; k++) begin
      checks++; if (got_idx[k] != exp_idx[k]) begin failures++; $display("FAIL mask_idx%0d got=%0d exp=%0d", k, got_idx[k], exp_idx[k]); end
      checks++; if (got_data[k] != 16'h10 + exp_idx[k]) begin failures++; $display("FAIL mask_data%0d got=%h exp=%h", k, got_data[k], 16'h10 + exp_idx[k]); end
    end
    checks++; if (reqhi[0] + reqhi[2] != 0) begin failures++; $display("FAIL mask_disabled_req got=%0d exp=0", reqhi[0] + reqhi[2]); end
  endtask

  task automatic test_timeout();
    int exp_idx[3] = '{0, 1, 3};
    bus.stream_en = 4'hF; bus.ack_in = 4'b1011; bus.ack_out = 1'b1;
    apply_reset();
    collect(3, 60);
    checks++; if (got_idx.size() != 3) begin failures++; $display("FAIL to_count got=%0d exp=3", got_idx.size()); end
    for (int k = 0; k < got_idx.size() && k < 3; k++) begin
      checks++; if (got_idx[k] != exp_idx[k]) begin failures++; $display("FAIL to_idx%0d got=%0d exp=%0d", k, got_idx[k], exp_idx[k]); end
    end
    if (got_cyc.size() == 3) begin
      checks++; if (got_cyc[2] - got_cyc[1] != 12) begin failures++; $display("FAIL to_gap got=%0d exp=12", got_cyc[2] - got_cyc[1]); end
    end
    checks++; if (reqhi[2] != TO) begin failures++; $display("FAIL to_req_cycles got=%0d exp=%0d", reqhi[2], TO); end
    checks++; if (bus.skip_cnt !== 16'd1) begin failures++; $display("FAIL to_skip_cnt got=%0d exp=1", bus.skip_cnt); end
    checks++; if (viol != 0) begin failures++; $display("FAIL to_protocol got=%0d exp=0", viol); end
  endtask

  task automatic test_back_pressure();
    int t = 0;
    bus.stream_en = 4'hF; bus.ack_in = 4'hF; bus.ack_out = 1'b0;
    apply_reset();
    while (!bus.req_out && t < 20) begin @(negedge clk); t++; end
    checks++; if (bus.req_out !== 1'b1) begin failures++; $display("FAIL bp_wait got=%b exp=1", bus.req_out); end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (bus.req_out !== 1'b1 || bus.idx_out !== 4'd0 || bus.data_out !== 16'h10 || bus.req_in !== 4'h0) begin
        failures++;
        $display("FAIL bp_hold%0d got req_out=%b idx=%h data=%h req_in=%h exp 1/0/0010/0", c, bus.req_out, bus.idx_out, bus.data_out, bus.req_in);
      end
    end
    bus.ack_out = 1'b1;
    @(negedge clk);
    bus.ack_out = 1'b0;
    checks++; if (bus.req_out !== 1'b0 || bus.data_out !== 16'h0) begin failures++; $display("FAIL bp_release got req_out=%b data=%h exp 0/0", bus.req_out, bus.data_out); end
    repeat (3) @(negedge clk);
    checks++; if (bus.req_out !== 1'b1 || bus.idx_out !== 4'd1 || bus.data_out !== 16'h11) begin failures++; $display("FAIL bp_next got req_out=%b idx=%h data=%h exp 1/1/0011", bus.req_out, bus.idx_out, bus.data_out); end
  endtask

  task automatic test_wrong_ack();
    int t = 0;
    bus.stream_en = 4'b0010; bus.ack_in = 4'b1000; bus.ack_out = 1'b1;
    apply_reset();
    while (bus.req_in !== 4'b0010 && t < 20) begin @(negedge clk); t++; end
    checks++; if (bus.req_in !== 4'b0010) begin failures++; $display("FAIL wa_fetch got=%h exp=2", bus.req_in); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (bus.req_in !== 4'b0010 || bus.req_out !== 1'b0) begin failures++; $display("FAIL wa_ignore%0d got req_in=%h req_out=%b exp 2/0", c, bus.req_in, bus.req_out); end
    end
    bus.ack_in = 4'b0010;
    @(negedge clk);
    checks++; if (bus.req_out !== 1'b1 || bus.idx_out !== 4'd1 || bus.data_out !== 16'h11) begin failures++; $display("FAIL wa_accept got req_out=%b idx=%h data=%h exp 1/1/0011", bus.req_out, bus.idx_out, bus.data_out); end
    checks++; if (bus.skip_cnt !== 16'd0) begin failures++; $display("FAIL wa_skip_cnt got=%0d exp=0", bus.skip_cnt); end
  endtask

  task automatic test_reset_mid_send();
    int t = 0;
    bus.stream_en = 4'b0100; bus.ack_in = 4'h0; bus.ack_out = 1'b0;
    apply_reset();
    while (bus.skip_cnt !== 16'd1 && t < 40) begin @(negedge clk); t++; end
    checks++; if (bus.skip_cnt !== 16'd1) begin failures++; $display("FAIL rms_skip got=%0d exp=1", bus.skip_cnt); end
    bus.ack_in = 4'b0100;
    t = 0;
    while (!bus.req_out && t < 40) begin @(negedge clk); t++; end
    checks++; if (bus.req_out !== 1'b1 || bus.idx_out !== 4'd2) begin failures++; $display("FAIL rms_send got req_out=%b idx=%h exp 1/2", bus.req_out, bus.idx_out); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_out !== 1'b0 || bus.data_out !== 16'h0 || bus.idx_out !== 4'h0 ||
        bus.req_in !== 4'h0 || bus.skip_cnt !== 16'h0 || bus.frame_end !== 1'b0) begin
      failures++;
      $display("FAIL rms_cleared got req_out=%b data=%h idx=%h req_in=%h skip=%h fe=%b exp all 0",
               bus.req_out, bus.data_out, bus.idx_out, bus.req_in, bus.skip_cnt, bus.frame_end);
    end
    bus.stream_en = 4'hF; bus.ack_in = 4'h0;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.req_in !== 4'b0001) begin failures++; $display("FAIL rms_ptr0 got=%h exp=1", bus.req_in); end
  endtask

  task automatic test_all_disabled();
    int tot = 0;
    bus.stream_en = 4'h0; bus.ack_in = 4'hF; bus.ack_out = 1'b1;
    apply_reset();
    collect(1, 16);
    for (int i = 0; i < NS; i++) tot += reqhi[i];
    checks++; if (tot != 0 || got_idx.size() != 0) begin failures++; $display("FAIL dis_no_req got reqs=%0d words=%0d exp 0/0", tot, got_idx.size()); end
    checks++; if (fe_cyc.size() != 4) begin failures++; $display("FAIL dis_fe_count got=%0d exp=4", fe_cyc.size()); end
    for (int k = 0; k < fe_cyc.size() && k < 4; k++) begin
      checks++; if (fe_cyc[k] != 4 * (k + 1)) begin failures++; $display("FAIL dis_fe%0d got=%0d exp=%0d", k, fe_cyc[k], 4 * (k + 1)); end
    end
  endtask

  initial begin
    bus.stream_en = '0;
    bus.ack_in    = '0;
    bus.ack_out   = 1'b0;
    for (int i = 0; i < NS; i++) bus.data_in[i*DW +: DW] = 16'(16'h10 + i);
    test_reset();
    test_rotation();
    test_mask();
    test_timeout();
    test_back_pressure();
    test_wrong_ack();
    test_reset_mid_send();
    test_all_disabled();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
